// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_scan_ctrl
//  Brief    : Fetches a digit glyph from a registered glyph ROM, holds it in a
//             pending buffer, and swaps it into the displayed frame buffer only
//             at a frame boundary while scanning an 8x8 LED matrix line by line.
//  Revision : 1.0 - initial release
// ============================================================================
module led_scan_ctrl #(
    parameter int LINE_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        pi_clk,
    input  logic        pi_rst,
    input  logic        pi_valid,
    input  logic [3:0]  pi_digit,
    output logic        po_ready,
    output logic        po_rom_en,
    output logic [3:0]  po_rom_addr,
    input  logic [63:0] pi_rom_data,
    output logic [7:0]  po_line,
    output logic [7:0]  po_pixels,
    output logic        po_frame
);

    localparam int CNT_W = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_LAST_CNT  = CNT_W'(LINE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_BLANK_CNT = CNT_W'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_capture;

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_line;
    logic [63:0]      r_frame_buf;
    logic [63:0]      r_pend_buf;
    logic             r_pend_valid;

    logic             w_cnt_wrap;
    logic             w_frame_wrap;
    logic             w_swap;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_line_nxt;
    logic [63:0]      w_frame_buf_nxt;
    logic             w_pend_valid_nxt;
    logic             w_blank_nxt;
    logic             w_ready_nxt;
    logic             w_rom_en_nxt;
    logic [7:0]       w_line_out_nxt;
    logic [7:0]       w_pixels_nxt;

    // Next-state logic for the scan engine, load FSM and registered outputs.
    // Outputs are registered from next-state values so they line up with the
    // counter/line/buffer contents they describe.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;

        w_cnt_wrap   = (r_cnt == c_LAST_CNT);
        w_frame_wrap = w_cnt_wrap && (r_line == 3'd7);
        w_cnt_nxt    = w_cnt_wrap ? '0 : r_cnt + 1'b1;
        w_line_nxt   = w_cnt_wrap ? r_line + 3'd1 : r_line;

        // The swap looks only at pre-edge pending contents, so a glyph that is
        // captured on a wrap edge waits for the following frame.
        w_swap          = w_frame_wrap && r_pend_valid;
        w_frame_buf_nxt = w_swap ? r_pend_buf : r_frame_buf;

        case (r_state)
            S_IDLE: begin
                if (pi_valid && po_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_capture   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_capture) begin
            w_pend_valid_nxt = 1'b1;
        end else if (w_swap) begin
            w_pend_valid_nxt = 1'b0;
        end else begin
            w_pend_valid_nxt = r_pend_valid;
        end

        w_ready_nxt    = (w_state_nxt == S_IDLE) && !w_pend_valid_nxt;
        w_rom_en_nxt   = (w_state_nxt == S_FETCH);
        w_blank_nxt    = (w_cnt_nxt < c_BLANK_CNT);
        w_line_out_nxt = w_blank_nxt ? 8'h00 : (8'h01 << w_line_nxt);
        w_pixels_nxt   = w_blank_nxt ? 8'h00 : w_frame_buf_nxt[{w_line_nxt, 3'b000} +: 8];
    end

    // Load FSM state register.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ROM request address, pending buffer and its valid flag.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            po_rom_addr  <= 4'h0;
            r_pend_buf   <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                po_rom_addr <= pi_digit;
            end
            if (w_capture) begin
                r_pend_buf <= pi_rom_data;
            end
            r_pend_valid <= w_pend_valid_nxt;
        end
    end

    // Free-running line scan counters and the displayed frame buffer.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            r_cnt       <= '0;
            r_line      <= 3'd0;
            r_frame_buf <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_line      <= w_line_nxt;
            r_frame_buf <= w_frame_buf_nxt;
        end
    end

    // Registered outputs; all low while reset is held.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            po_ready  <= 1'b0;
            po_rom_en <= 1'b0;
            po_line   <= 8'h00;
            po_pixels <= 8'h00;
            po_frame  <= 1'b0;
        end else begin
            po_ready  <= w_ready_nxt;
            po_rom_en <= w_rom_en_nxt;
            po_line   <= w_line_out_nxt;
            po_pixels <= w_pixels_nxt;
            po_frame  <= w_frame_wrap;
        end
    end

endmodule
`default_nettype wire

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Sequencer between the 16-entry glyph ROM (64-bit, 1-cycle registered read, enable-gated) and the 8x8 LED matrix driver pins. It accepts a digit code over a valid/ready handshake, fetches the glyph from the ROM, double-buffers it, and continuously multiplexes the matrix one line at a time. New glyphs are swapped in only at a frame boundary, so no frame ever mixes two glyphs.

## Interface
- LINE_CYCLES, 1000: clock cycles each line is selected. Legal range 2..65535.
- BLANK_CYCLES, 2: leading cycles of each line slot with all lines off (anti-ghosting). Must be less than LINE_CYCLES.
- pi_clk  in  1  system clock, rising edge.
- pi_rst  in  1  reset, asynchronous, active-high.
- pi_valid  in  1  digit request valid.
- pi_digit  in  4  digit code; values 10..15 pass through unchanged (ROM returns its error glyph).
- po_ready  out  1  controller can accept a request.
- po_rom_en  out  1  ROM read enable.
- po_rom_addr  out  4  ROM address.
- pi_rom_data  in  64  ROM glyph, valid the cycle after po_rom_en.
- po_line  out  8  one-hot line select, active-high.
- po_pixels  out  8  pixel data for the selected line.
- po_frame  out  1  one-cycle pulse when line 7 ends (frame boundary).

## Operation
- Glyph layout: line k uses byte k of the glyph, bits [8k+7:8k].
- Buffers: frame buffer (64b, displayed) and pending buffer (64b) plus pending_valid flag.
- Load FSM:
  - IDLE: po_ready=1 iff pending_valid=0. Handshake on pi_valid & po_ready -> latch pi_digit into po_rom_addr, go FETCH.
  - FETCH (1 cycle): po_rom_en=1 -> WAIT.
  - WAIT (1 cycle): po_rom_en=0; capture pi_rom_data into the pending buffer, set pending_valid -> IDLE.
  - po_ready=0 in FETCH and WAIT. po_rom_en=0 outside FETCH.
- Scan engine (free-running from reset release):
  - Cycle counter 0..LINE_CYCLES-1 and line index 0..7.
  - po_line = 0 while the cycle counter < BLANK_CYCLES, else one-hot(line). po_pixels = frame byte[line] during lit cycles, 0 while blanked.
  - At counter wrap: line increments. When line wraps 7->0: po_frame pulses, and if pending_valid is set, the frame buffer takes the pending buffer and pending_valid clears, all on the same edge.
- Simultaneous events: a WAIT capture and a frame wrap on the same edge -> the new glyph lands in pending and is shown from the next frame. The swap uses the pre-edge pending contents.
- A second request is stalled (po_ready=0) until the pending glyph has been swapped.
- Reset (asynchronous, any time, including mid-fetch): FSM=IDLE, pending_valid=0, both buffers=0 (blank), counter=0, line=0, po_rom_addr=0.
- Output values during reset: po_rom_en=0, po_line=0, po_pixels=0, po_frame=0, po_ready=0 while pi_rst is high and 1 after release.

## Timing
- Request accepted at edge E0. po_rom_en is high in the cycle after E0. The ROM registers the data at edge E1 and the pending buffer captures it at E2.
- po_ready is back high after E2 only if the pending glyph has already been swapped. Otherwise it stays low until the swap edge.
- Display latency: from pending capture to the first displayed line of the new glyph is at most 8*LINE_CYCLES cycles, and the glyph starts at line 0.
- Frame period is exactly 8*LINE_CYCLES cycles. po_frame is high for the one cycle following the 7->0 wrap edge.
- All outputs are registered. No combinational path runs from pi_* to po_*.

## Test plan
- Reset then idle (LINE_CYCLES=4, BLANK_CYCLES=1): po_line runs 00,01,01,01,00,02,02,02,... and po_pixels stays 00 throughout. po_frame pulses every 32 cycles.
- Load digit 1 (ROM glyph 64'h000082ff80000000): po_rom_en high exactly 1 cycle with addr 4'h1. From the next frame, lit cycles show pixels 00,00,00,80,ff,82,00,00 on lines 0..7.
- Back-to-back requests 3 then 7: the second is held off (po_ready=0) until the frame swap of 3. Frames show 3 entirely, then 7 entirely, with no mixed frame.
- Capture coincident with frame wrap: time the request so WAIT lands on the wrap edge. The old glyph stays for one more full frame, then the new glyph appears.
- Digit 4'hC: the ROM returns 64'h8142241818244281. The error pattern is displayed (line 0 pixels 81, line 3 pixels 18).
- Async reset asserted in FETCH: all outputs go 0 immediately and no pending glyph survives. After release, the display is blank and po_ready=1.
